stopwatch_button_ctrl: RTL

Front-end command sequencer for the stopwatch control FSM and display path. It converts two raw push-buttons (start/stop and lap/clear) into clean single-cycle start, stop and clear command pulses, plus a lap-freeze level for the display latch. It synchronises and debounces both buttons and distinguishes short presses from long presses. It sits between the board buttons and the control FSM's start/stop/reset inputs, and takes the FSM's running status back as an input.

---
 rtl/stopwatch_button_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_button_ctrl.sv
// Button front end for the stopwatch: synchronises and debounces start/stop and lap/clear,
// then turns them into single-cycle start/stop/clear commands and a lap-freeze level.
module stopwatch_button_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int LONG_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_lap,
  input  logic running,
  output logic start_pulse,
  output logic stop_pulse,
  output logic clr_pulse,
  output logic lap_pulse,
  output logic lap_freeze
);

  typedef enum logic [1:0] {L_IDLE, L_HELD, L_LONG} lap_state_t;

  logic [1:0] btn_raw;
  logic [1:0] deb_lvl;
  logic [1:0] deb_tog;

  assign btn_raw = {btn_lap, btn_ss};

  // Index 0 is start/stop, index 1 is lap/clear.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic             meta_reg;
      logic             sync_reg;
      logic             deb_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          deb_reg  <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= btn_raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      // High in the cycle before the debounced level flips.
      assign deb_tog[gi] = (sync_reg != deb_reg) && (cnt_reg == CNT_W'(DEB_CYCLES - 1));
      assign deb_lvl[gi] = deb_reg;
    end
  endgenerate

  logic ss_deb_d_reg;
  logic ss_rise;
  logic lap_rise_evt;
  logic lap_fall_evt;

  assign ss_rise      = deb_lvl[0] & ~ss_deb_d_reg;
  assign lap_rise_evt = deb_tog[1] & ~deb_lvl[1];
  assign lap_fall_evt = deb_tog[1] & deb_lvl[1];

  lap_state_t       state_reg, state_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic             long_hit;
  logic             short_rel;
  logic             start_next, stop_next, clr_next, lap_pulse_next, lap_freeze_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= L_IDLE;
      hold_reg     <= '0;
      ss_deb_d_reg <= 1'b0;
      start_pulse  <= 1'b0;
      stop_pulse   <= 1'b0;
      clr_pulse    <= 1'b0;
      lap_pulse    <= 1'b0;
      lap_freeze   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      ss_deb_d_reg <= deb_lvl[0];
      start_pulse  <= start_next;
      stop_pulse   <= stop_next;
      clr_pulse    <= clr_next;
      lap_pulse    <= lap_pulse_next;
      lap_freeze   <= lap_freeze_next;
    end
  end

  // Reaching the long-press threshold wins over a release arriving on the same edge.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    long_hit   = 1'b0;
    short_rel  = 1'b0;
    case (state_reg)
      L_IDLE: begin
        if (lap_rise_evt) begin
          state_next = L_HELD;
          hold_next  = CNT_W'(1);
        end
      end
      L_HELD: begin
        if (hold_reg == CNT_W'(LONG_CYCLES - 1)) begin
          state_next = L_LONG;
          hold_next  = CNT_W'(LONG_CYCLES);
          long_hit   = 1'b1;
        end else if (lap_fall_evt) begin
          state_next = L_IDLE;
          short_rel  = 1'b1;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      L_LONG: begin
        if (lap_fall_evt) begin
          state_next = L_IDLE;
        end
      end
      default: begin
        state_next = L_IDLE;
      end
    endcase
  end

  // A clear discards any start/stop decided on the same edge.
  always_comb begin
    clr_next        = long_hit;
    start_next      = ss_rise & ~running & ~long_hit;
    stop_next       = ss_rise & running & ~long_hit;
    lap_pulse_next  = short_rel & running & ~lap_freeze;
    lap_freeze_next = lap_freeze;
    if (long_hit) begin
      lap_freeze_next = 1'b0;
    end else if (short_rel) begin
      if (lap_freeze) begin
        lap_freeze_next = 1'b0;
      end else if (running) begin
        lap_freeze_next = 1'b1;
      end
    end
  end

endmodule
